clock_display_scan: RTL and testbench

Downstream display stage of the digital clock: consumes the clock core's time digits (h1, h0, m1, m0, s1, s0) and am/pm/alarm flags, and drives a six-digit, time-multiplexed, common-anode 7-segment display. Each scan frame works from a snapshot of the time, taken once per frame, so a digit rollover never tears the display. While the alarm output is active, the whole display blinks. AM/PM indicator LEDs are driven in 12-hour mode.

---
 rtl/clock_display_scan.sv | 167 ++++++++++++++++
 tb/tb_clock_display_scan.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for the clock core. Each scan frame
// displays a per-frame snapshot of the time; the whole display blinks while the alarm is active.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       r,
  input  logic [2:0] h1,
  input  logic [4:0] h0,
  input  logic [3:0] m1,
  input  logic [4:0] m0,
  input  logic [3:0] s1,
  input  logic [4:0] s0,
  input  logic       am,
  input  logic       pm,
  input  logic       a_out,
  input  logic       hour_24,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       led_am,
  output logic       led_pm
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrmW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmMax = FrmW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [2:0] h1;
    logic [4:0] h0;
    logic [3:0] m1;
    logic [4:0] m0;
    logic [3:0] s1;
    logic [4:0] s0;
    logic       am;
    logic       pm;
    logic       a_out;
    logic       hour_24;
    logic       blank_lz;
  } snap_t;

  logic [DivW-1:0] r_div, w_div_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [FrmW-1:0] r_frame, w_frame_d;
  logic            r_blink, w_blink_d;
  logic            r_start, w_start_d;
  snap_t           r_snap, w_snap_d;
  logic            w_load;

  logic [6:0] r_seg, w_seg_d;
  logic       r_dp, w_dp_d;
  logic [5:0] r_an, w_an_d;
  logic       r_led_am, r_led_pm;
  logic [4:0] w_digit;

  function automatic logic [6:0] f_decode(input logic [4:0] v);
    case (v)
      5'd0:    f_decode = 7'h40;
      5'd1:    f_decode = 7'h79;
      5'd2:    f_decode = 7'h24;
      5'd3:    f_decode = 7'h30;
      5'd4:    f_decode = 7'h19;
      5'd5:    f_decode = 7'h12;
      5'd6:    f_decode = 7'h02;
      5'd7:    f_decode = 7'h78;
      5'd8:    f_decode = 7'h00;
      5'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  // Scan counters; a frame wrap reloads the snapshot and advances the blink divider.
  always_comb begin
    w_div_d   = r_div;
    w_idx_d   = r_idx;
    w_frame_d = r_frame;
    w_blink_d = r_blink;
    w_start_d = r_start;
    w_load    = 1'b0;
    if (r_start) begin
      w_load    = 1'b1;
      w_idx_d   = '0;
      w_div_d   = '0;
      w_start_d = 1'b0;
    end else if (r_div == DivMax) begin
      w_div_d = '0;
      if (r_idx == 3'd5) begin
        w_idx_d = '0;
        w_load  = 1'b1;
        if (r_frame == FrmMax) begin
          w_frame_d = '0;
          w_blink_d = ~r_blink;
        end else begin
          w_frame_d = r_frame + 1'b1;
        end
      end else begin
        w_idx_d = r_idx + 3'd1;
      end
    end else begin
      w_div_d = r_div + 1'b1;
    end
    w_snap_d = w_load ? snap_t'{h1, h0, m1, m0, s1, s0, am, pm, a_out, hour_24, blank_lz}
                      : r_snap;
  end

  // Outputs are decoded from next-state values so they carry no extra latency.
  always_comb begin
    w_digit = '0;
    w_dp_d  = 1'b1;
    case (w_idx_d)
      3'd0:    w_digit = w_snap_d.s0;
      3'd1:    w_digit = {1'b0, w_snap_d.s1};
      3'd2:    begin w_digit = w_snap_d.m0; w_dp_d = 1'b0; end
      3'd3:    w_digit = {1'b0, w_snap_d.m1};
      3'd4:    begin w_digit = w_snap_d.h0; w_dp_d = 1'b0; end
      default: w_digit = {2'b00, w_snap_d.h1};
    endcase
    w_seg_d = f_decode(w_digit);
    if (w_idx_d == 3'd5 && w_snap_d.blank_lz && w_snap_d.h1 == 3'd0) begin
      w_seg_d = 7'h7F;
    end
    if (w_snap_d.a_out && w_blink_d) begin
      w_seg_d = 7'h7F;
      w_dp_d  = 1'b1;
    end
    w_an_d = ~(6'b000001 << w_idx_d);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_div    <= '0;
      r_idx    <= '0;
      r_frame  <= '0;
      r_blink  <= 1'b0;
      r_start  <= 1'b1;
      r_snap   <= '0;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
      r_an     <= 6'h3F;
      r_led_am <= 1'b0;
      r_led_pm <= 1'b0;
    end else begin
      r_div    <= w_div_d;
      r_idx    <= w_idx_d;
      r_frame  <= w_frame_d;
      r_blink  <= w_blink_d;
      r_start  <= w_start_d;
      r_snap   <= w_snap_d;
      r_seg    <= w_seg_d;
      r_dp     <= w_dp_d;
      r_an     <= w_an_d;
      r_led_am <= w_snap_d.am & ~w_snap_d.hour_24;
      r_led_pm <= w_snap_d.pm & ~w_snap_d.hour_24;
    end
  end

  assign seg    = r_seg;
  assign dp     = r_dp;
  assign an     = r_an;
  assign led_am = r_led_am;
  assign led_pm = r_led_pm;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: stimulus queues expected outputs per edge number,
// a monitor pops and compares them as the scan reaches those edges.
module tb_clock_display_scan;

  logic       clk, rst_n;
  logic [2:0] h1;
  logic [4:0] h0, m0, s0;
  logic [3:0] m1, s1;
  logic       am, pm, a_out, hour_24, blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       led_am, led_pm;

  clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .r(rst_n), .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .am(am), .pm(pm), .a_out(a_out), .hour_24(hour_24), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .led_am(led_am), .led_pm(led_pm)
  );

  typedef struct {
    int         e;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       lam;
    logic       lpm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 1 is the first rising edge after reset release (the start edge).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic push(input int e, input logic [6:0] s, input logic d, input logic [5:0] a,
                      input logic la, input logic lp);
    exp_t x;
    x.e = e; x.seg = s; x.dp = d; x.an = a; x.lam = la; x.lpm = lp;
    exp_q.push_back(x);
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({seg, dp, an, led_am, led_pm} !== {7'h7F, 1'b1, 6'h3F, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s: seg=%h dp=%b an=%b am=%b pm=%b, want seg=7f dp=1 an=111111 leds=0",
               name, seg, dp, an, led_am, led_pm);
    end
  endtask

  // Monitor: compare whenever the scan reaches the edge of the queue head.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && rst_n && exp_q[0].e <= edge_n) begin
      exp_t x;
      x = exp_q.pop_front();
      total++;
      if (x.e < edge_n) begin
        bad++;
        $display("FAIL missed edge %0d: now at edge %0d", x.e, edge_n);
      end else if ({seg, dp, an, led_am, led_pm} !== {x.seg, x.dp, x.an, x.lam, x.lpm}) begin
        bad++;
        $display("FAIL edge %0d: seg=%h dp=%b an=%b am=%b pm=%b, want seg=%h dp=%b an=%b am=%b pm=%b",
                 x.e, seg, dp, an, led_am, led_pm, x.seg, x.dp, x.an, x.lam, x.lpm);
      end
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d expectations never reached", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    h1 = 3'd1; h0 = 5'd2; m1 = 4'd3; m0 = 5'd4; s1 = 4'd5; s0 = 5'd6;
    am = 1'b0; pm = 1'b1; a_out = 1'b0; hour_24 = 1'b1; blank_lz = 1'b0;
    #11;
    check_reset("initial reset");

    // 12:34:56 in 24-hour mode, snapshot isolation, meridian LEDs, a_out=0 never blanks.
    push(1,  7'h02, 1'b1, 6'b111110, 1'b0, 1'b0);
    push(4,  7'h02, 1'b1, 6'b111110, 1'b0, 1'b0);
    push(5,  7'h12, 1'b1, 6'b111101, 1'b0, 1'b0);
    push(9,  7'h19, 1'b0, 6'b111011, 1'b0, 1'b0);
    push(13, 7'h30, 1'b1, 6'b110111, 1'b0, 1'b0);
    push(17, 7'h24, 1'b0, 6'b101111, 1'b0, 1'b0);
    push(21, 7'h79, 1'b1, 6'b011111, 1'b0, 1'b0);
    push(24, 7'h79, 1'b1, 6'b011111, 1'b0, 1'b0);
    push(25, 7'h78, 1'b1, 6'b111110, 1'b0, 1'b0);
    push(48, 7'h79, 1'b1, 6'b011111, 1'b0, 1'b0);
    push(49, 7'h78, 1'b1, 6'b111110, 1'b0, 1'b1);
    push(53, 7'h12, 1'b1, 6'b111101, 1'b0, 1'b1);
    push(73, 7'h78, 1'b1, 6'b111110, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    wait_edge(10); s0 = 5'd7;
    wait_edge(26); hour_24 = 1'b0;
    wait_edge(50); hour_24 = 1'b1;
    wait_edge(80);
    drain("phase 1");

    // Mid-cycle reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset("mid-frame reset");
    h1 = 3'd0; h0 = 5'd9; m1 = 4'd5; m0 = 5'd12; s1 = 4'd0; s0 = 5'd8;
    am = 1'b1; pm = 1'b0; a_out = 1'b1; hour_24 = 1'b0; blank_lz = 1'b1;

    // Blanked leading zero, invalid digit dash, alarm blink frames 2-3, AM LED.
    push(1,   7'h00, 1'b1, 6'b111110, 1'b1, 1'b0);
    push(5,   7'h40, 1'b1, 6'b111101, 1'b1, 1'b0);
    push(9,   7'h3F, 1'b0, 6'b111011, 1'b1, 1'b0);
    push(13,  7'h12, 1'b1, 6'b110111, 1'b1, 1'b0);
    push(17,  7'h10, 1'b0, 6'b101111, 1'b1, 1'b0);
    push(21,  7'h7F, 1'b1, 6'b011111, 1'b1, 1'b0);
    push(48,  7'h7F, 1'b1, 6'b011111, 1'b1, 1'b0);
    push(49,  7'h7F, 1'b1, 6'b111110, 1'b1, 1'b0);
    push(57,  7'h7F, 1'b1, 6'b111011, 1'b1, 1'b0);
    push(96,  7'h7F, 1'b1, 6'b011111, 1'b1, 1'b0);
    push(97,  7'h00, 1'b1, 6'b111110, 1'b1, 1'b0);
    push(105, 7'h3F, 1'b0, 6'b111011, 1'b1, 1'b0);
    push(141, 7'h40, 1'b1, 6'b011111, 1'b1, 1'b0);
    push(145, 7'h7F, 1'b1, 6'b111110, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(98); blank_lz = 1'b0;
    wait_edge(150);
    drain("phase 2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
